// File: rtl/sifh_peak_finder_pkg.sv
// Shared constants and state encoding for the SiFH histogram peak finder.
package sifh_peak_finder_pkg;

    localparam int NB_DEF       = 6;
    localparam int PEAK_MAX_DEF = 8;
    localparam int RAM_ADDR_DEF = 10;
    localparam int HALF_WIN_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FILTER = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/sifh_peak_finder_if.sv
// Control handshake, result bus and SRAM port-b signals of the peak finder.
// master = SiFH sequencer + SRAM side, slave = the peak finder itself.
interface sifh_peak_finder_if #(
    parameter int NB       = sifh_peak_finder_pkg::NB_DEF,
    parameter int PEAK_MAX = sifh_peak_finder_pkg::PEAK_MAX_DEF,
    parameter int RAM_ADDR = sifh_peak_finder_pkg::RAM_ADDR_DEF
);
    logic                   start;
    logic [RAM_ADDR-NB-1:0] pixIdx;
    logic [RAM_ADDR-1:0]    raddr;
    logic                   rEnable;
    logic                   readFlag;
    logic [PEAK_MAX-1:0]    counts;
    logic                   busy;
    logic                   done;
    logic [NB-1:0]          peakBin;
    logic [PEAK_MAX-1:0]    peakCount;
    logic [NB-1:0]          thMinus;
    logic [NB-1:0]          thPlus;

    modport master (
        output start, pixIdx, counts,
        input  raddr, rEnable, readFlag, busy, done,
               peakBin, peakCount, thMinus, thPlus
    );

    modport slave (
        input  start, pixIdx, counts,
        output raddr, rEnable, readFlag, busy, done,
               peakBin, peakCount, thMinus, thPlus
    );
endinterface

// File: rtl/sifh_window_calc.sv
// Filter window bounds around a peak bin, saturated to [0, 2**NB-1].
// Arithmetic is carried at NB+1 bits so the upper sum cannot wrap.
module sifh_window_calc #(
    parameter int NB       = 6,
    parameter int HALF_WIN = 4
) (
    input  logic [NB-1:0] i_bin,
    output logic [NB-1:0] o_th_minus,
    output logic [NB-1:0] o_th_plus
);
    localparam logic [NB:0] W_HW  = (NB+1)'(HALF_WIN);
    localparam logic [NB:0] W_TOP = (NB+1)'((2**NB) - 1);

    logic [NB:0] w_bin_ext;
    logic [NB:0] w_lo;
    logic [NB:0] w_hi;

    // Saturating subtract / add of the half window
    always_comb begin
        w_bin_ext = {1'b0, i_bin};
        w_lo      = (w_bin_ext < W_HW) ? '0 : (w_bin_ext - W_HW);
        w_hi      = w_bin_ext + W_HW;
        if (w_hi > W_TOP) begin
            w_hi = W_TOP;
        end
        o_th_minus = w_lo[NB-1:0];
        o_th_plus  = w_hi[NB-1:0];
    end
endmodule

// File: rtl/sifh_peak_finder.sv
// SiFH peak finder: scans one pixel's histogram from SRAM port b, keeps the
// first maximum bin and derives a filter window around it.
// Optional feature macro: SIFH_FILTER_WINDOW_EN (window around the peak);
// when undefined the window spans the whole histogram.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for start, SRAM port idle
//  ST_SCAN   | one read per cycle, addresses pixIdx*BIN_NUM + 0..BIN_NUM-1
//  ST_DRAIN  | port idle, last read data is compared
//  ST_FILTER | running max and window are copied to the outputs
//  ST_DONE   | one-cycle done pulse
module sifh_peak_finder #(
    parameter int NB       = sifh_peak_finder_pkg::NB_DEF,
    parameter int PEAK_MAX = sifh_peak_finder_pkg::PEAK_MAX_DEF,
    parameter int RAM_ADDR = sifh_peak_finder_pkg::RAM_ADDR_DEF,
    parameter int HALF_WIN = sifh_peak_finder_pkg::HALF_WIN_DEF
) (
    input logic               clk,
    input logic               res,
    sifh_peak_finder_if.slave bus
);
    import sifh_peak_finder_pkg::*;

    localparam logic [RAM_ADDR-1:0] W_ONE = RAM_ADDR'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RAM_ADDR-1:0] r_raddr;
    logic                r_dvalid;
    logic [NB-1:0]       r_dbin;
    logic [PEAK_MAX-1:0] r_max_cnt;
    logic [NB-1:0]       r_max_bin;
    logic [NB-1:0]       r_peak_bin;
    logic [PEAK_MAX-1:0] r_peak_cnt;
    logic [NB-1:0]       r_th_minus;
    logic [NB-1:0]       r_th_plus;
    logic [NB-1:0]       w_th_minus;
    logic [NB-1:0]       w_th_plus;
    logic                w_last_bin;
    logic                w_accept;

    assign w_last_bin = &r_raddr[NB-1:0];
    assign w_accept   = (r_state == ST_IDLE) && bus.start;

`ifdef SIFH_FILTER_WINDOW_EN
    sifh_window_calc #(
        .NB       (NB),
        .HALF_WIN (HALF_WIN)
    ) u_window_calc (
        .i_bin      (r_max_bin),
        .o_th_minus (w_th_minus),
        .o_th_plus  (w_th_plus)
    );
`else
    assign w_th_minus = '0;
    assign w_th_plus  = '1;
`endif

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_SCAN;
            ST_SCAN:   if (w_last_bin) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  w_state_nxt = ST_FILTER;
            ST_FILTER: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Read address: loaded with the pixel base on start, stepped through the
    // bins during SCAN, held everywhere else
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_raddr <= '0;
        end else if (w_accept) begin
            r_raddr <= {bus.pixIdx, {NB{1'b0}}};
        end else if ((r_state == ST_SCAN) && !w_last_bin) begin
            r_raddr <= r_raddr + W_ONE;
        end
    end

    // Track which bin the read data on counts belongs to (one-cycle SRAM latency)
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_dvalid <= 1'b0;
            r_dbin   <= '0;
        end else begin
            r_dvalid <= (r_state == ST_SCAN);
            r_dbin   <= r_raddr[NB-1:0];
        end
    end

    // Running maximum; strictly-greater update keeps the lowest bin on ties
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_max_cnt <= '0;
            r_max_bin <= '0;
        end else if (w_accept) begin
            r_max_cnt <= '0;
            r_max_bin <= '0;
        end else if (r_dvalid && (bus.counts > r_max_cnt)) begin
            r_max_cnt <= bus.counts;
            r_max_bin <= r_dbin;
        end
    end

    // Result registers, refreshed only in FILTER
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_peak_bin <= '0;
            r_peak_cnt <= '0;
            r_th_minus <= '0;
            r_th_plus  <= '0;
        end else if (r_state == ST_FILTER) begin
            r_peak_bin <= r_max_bin;
            r_peak_cnt <= r_max_cnt;
            r_th_minus <= w_th_minus;
            r_th_plus  <= w_th_plus;
        end
    end

    assign bus.raddr     = r_raddr;
    assign bus.readFlag  = (r_state == ST_SCAN);
    assign bus.rEnable   = (r_state != ST_SCAN);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.peakBin   = r_peak_bin;
    assign bus.peakCount = r_peak_cnt;
    assign bus.thMinus   = r_th_minus;
    assign bus.thPlus    = r_th_plus;
endmodule

// File: tb/tb_sifh_peak_finder.sv
// Directed bench for sifh_peak_finder with a one-cycle-latency SRAM model.
`timescale 1ns/1ps
module tb_sifh_peak_finder;
    import sifh_peak_finder_pkg::*;

    localparam int BIN_NUM = 2**NB_DEF;
    localparam int LAT     = BIN_NUM + 3;

    typedef struct {
        int pix;
        int bin_a;
        int val_a;
        int bin_b;
        int val_b;
        int exp_bin;
        int exp_cnt;
        int exp_thm;
        int exp_thp;
        int poke;
    } vec_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [7:0] mem [0:1023];
    vec_t vecs [9];

    always #5 clk = ~clk;

    sifh_peak_finder_if bus ();

    sifh_peak_finder dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.readFlag && !bus.rEnable) bus.counts <= mem[bus.raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 1024; i++) mem[i] = 8'd251;
        for (int b = 0; b < BIN_NUM; b++) mem[v.pix*BIN_NUM + b] = 8'd0;
        if (v.bin_a >= 0) mem[v.pix*BIN_NUM + v.bin_a] = 8'(v.val_a);
        if (v.bin_b >= 0) mem[v.pix*BIN_NUM + v.bin_b] = 8'(v.val_b);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, nreads, seq_err, busy_err, lat, base, hold_ok;
        int prev_pb, prev_pc, prev_thm, prev_thp, e_thm, e_thp;
        string t;
        t = $sformatf("v%0d", idx);
        base = v.pix * BIN_NUM;
`ifdef SIFH_FILTER_WINDOW_EN
        e_thm = v.exp_thm;
        e_thp = v.exp_thp;
`else
        e_thm = 0;
        e_thp = BIN_NUM - 1;
`endif
        prev_pb  = int'(bus.peakBin);
        prev_pc  = int'(bus.peakCount);
        prev_thm = int'(bus.thMinus);
        prev_thp = int'(bus.thPlus);
        load(v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.pixIdx = 4'(v.pix);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; nreads = 0; seq_err = 0; busy_err = 0; lat = -1; hold_ok = 1;
        while (cyc < 200) begin
            if (bus.readFlag) begin
                if (bus.rEnable || int'(bus.raddr) != base + nreads) seq_err++;
                nreads++;
            end else if (!bus.rEnable) begin
                seq_err++;
            end
            if (bus.done) begin
                lat = cyc;
                break;
            end
            if (!bus.busy) busy_err++;
            if (int'(bus.peakBin) != prev_pb || int'(bus.peakCount) != prev_pc ||
                int'(bus.thMinus) != prev_thm || int'(bus.thPlus) != prev_thp) hold_ok = 0;
            if (v.poke != 0 && cyc == 10) begin
                bus.start  = 1'b1;
                bus.pixIdx = 4'(v.pix + 1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({t, " latency"}, lat, LAT);
        check({t, " reads"}, nreads, BIN_NUM);
        check({t, " raddr_seq_err"}, seq_err, 0);
        check({t, " busy_drop"}, busy_err, 0);
        check({t, " hold_before_filter"}, hold_ok, 1);
        check({t, " peakBin"}, int'(bus.peakBin), v.exp_bin);
        check({t, " peakCount"}, int'(bus.peakCount), v.exp_cnt);
        check({t, " thMinus"}, int'(bus.thMinus), e_thm);
        check({t, " thPlus"}, int'(bus.thPlus), e_thp);
        @(negedge clk);
        check({t, " done_width"}, int'(bus.done), 0);
        check({t, " busy_after"}, int'(bus.busy), 0);
        check({t, " idle_readFlag"}, int'(bus.readFlag), 0);
        check({t, " last_raddr"}, int'(bus.raddr), base + BIN_NUM - 1);
        check({t, " peakBin_held"}, int'(bus.peakBin), v.exp_bin);
    endtask

    initial begin
        int dcount;
        vec_t vr;
        bus.start  = 1'b0;
        bus.pixIdx = '0;
        //         pix bin_a val_a bin_b val_b  eb  ec thm thp poke
        vecs[0] = '{ 2, 30, 200, -1,  0, 30, 200, 26, 34, 0};
        vecs[1] = '{ 3, 10,  50, 40, 50, 10,  50,  6, 14, 1};
        vecs[2] = '{ 4,  2,  77, -1,  0,  2,  77,  0,  6, 0};
        vecs[3] = '{ 5, 62,   9, -1,  0, 62,   9, 58, 63, 0};
        vecs[4] = '{15, -1,   0, -1,  0,  0,   0,  0,  4, 0};
        vecs[5] = '{ 0, 63, 255,  0, 254, 63, 255, 59, 63, 0};
        vecs[6] = '{ 7,  0,   5,  1,  6,  1,   6,  0,  5, 0};
        vecs[7] = '{ 9,  4,   1, -1,  0,  4,   1,  0,  8, 0};
        vecs[8] = '{12, 59,   3, -1,  0, 59,   3, 55, 63, 0};

        #1 res = 1'b0;
        #1;
        check("rst raddr", int'(bus.raddr), 0);
        check("rst rEnable", int'(bus.rEnable), 1);
        check("rst readFlag", int'(bus.readFlag), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        check("rst peakBin", int'(bus.peakBin), 0);
        check("rst peakCount", int'(bus.peakCount), 0);
        check("rst thMinus", int'(bus.thMinus), 0);
        check("rst thPlus", int'(bus.thPlus), 0);
        repeat (2) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset mid-scan: abort, outputs cleared asynchronously, no done pulse
        load(vecs[0]);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.pixIdx = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("mid busy_before_rst", int'(bus.busy), 1);
        res = 1'b0;
        #1;
        check("mid rst busy", int'(bus.busy), 0);
        check("mid rst readFlag", int'(bus.readFlag), 0);
        check("mid rst rEnable", int'(bus.rEnable), 1);
        check("mid rst raddr", int'(bus.raddr), 0);
        check("mid rst peakBin", int'(bus.peakBin), 0);
        check("mid rst peakCount", int'(bus.peakCount), 0);
        check("mid rst thPlus", int'(bus.thPlus), 0);
        @(negedge clk);
        res = 1'b1;
        dcount = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        check("mid no_done_after_abort", dcount, 0);
        vr = '{1, 45, 123, -1, 0, 45, 123, 41, 49, 0};
        run_vec(vr, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
